y_requant_fifo: RTL and testbench

Downstream stage of the 8x4 convolution core. Accepts the 18-bit signed y stream over a valid/ready handshake and optionally applies ReLU. It then requantizes each sample to 8 bits signed with a rounding arithmetic right shift and saturation, and buffers the results in a DEPTH-entry FIFO. The FIFO drains over a second valid/ready interface, so convolution output is decoupled from a slow consumer.

---
 rtl/y_requant_fifo.sv | 113 +++++++++++
 tb/tb_y_requant_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/y_requant_fifo.sv
// y_requant_fifo: ReLU (optional) + rounding right shift + saturate to OUT_W,
// buffered in a DEPTH-entry FIFO with valid/ready on both sides.
// Optional feature macro: Y_REQUANT_RELU_EN (force negative inputs to zero).
module y_requant_fifo #(
  parameter int unsigned IN_W     = 18,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned SHIFT    = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned LOGDEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_W-1:0]       s_data_in_y,
  input  logic                  s_valid_y,
  output logic                  s_ready_y,
  output logic [OUT_W-1:0]      m_data_out_z,
  output logic                  m_valid_z,
  input  logic                  m_ready_z,
  output logic [LOGDEPTH:0]     fill,
  output logic [7:0]            sat_count
);

  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_W:0] RND =
    (SHIFT > 0) ? ((IN_W+1)'(1) << RND_SH) : '0;
  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] MIN_V = ~MAX_V;
  localparam logic [LOGDEPTH:0]    FULL_FILL = (LOGDEPTH+1)'(DEPTH);

  logic signed [IN_W:0]  v_c, r_c, q_c;
  logic [OUT_W-1:0]      z_c;
  logic                  sat_c;
  logic                  full_c, push_c, pop_c;

  logic [LOGDEPTH:0]     fill_q, fill_d;
  logic [LOGDEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LOGDEPTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]            sat_count_q, sat_count_d;
  logic [OUT_W-1:0]      mem_q [DEPTH];

  // Requantize the incoming sample: relu, round, arithmetic shift, clip.
  always_comb begin
    v_c = {s_data_in_y[IN_W-1], s_data_in_y};
`ifdef Y_REQUANT_RELU_EN
    if (s_data_in_y[IN_W-1]) v_c = '0;
`endif
    r_c   = v_c + RND;
    q_c   = r_c >>> SHIFT;
    z_c   = q_c[OUT_W-1:0];
    sat_c = 1'b0;
    if (q_c > MAX_V) begin
      z_c   = MAX_V[OUT_W-1:0];
      sat_c = 1'b1;
    end else if (q_c < MIN_V) begin
      z_c   = MIN_V[OUT_W-1:0];
      sat_c = 1'b1;
    end
  end

  // Handshake decode from registered occupancy; no bypass when full.
  always_comb begin
    full_c    = (fill_q == FULL_FILL);
    s_ready_y = !full_c && !reset;
    m_valid_z = (fill_q != '0);
    push_c    = s_valid_y && s_ready_y;
    pop_c     = m_valid_z && m_ready_z;
  end

  // Next-state for pointers, occupancy and the clip counter.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    sat_count_d = sat_count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + LOGDEPTH'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + LOGDEPTH'(1);
    case ({push_c, pop_c})
      2'b10:   fill_d = fill_q + (LOGDEPTH+1)'(1);
      2'b01:   fill_d = fill_q - (LOGDEPTH+1)'(1);
      default: fill_d = fill_q;
    endcase
    if (push_c && sat_c && (sat_count_q != 8'hFF))
      sat_count_d = sat_count_q + 8'd1;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      sat_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      sat_count_q <= sat_count_d;
    end
  end

  // Storage array; contents need no reset because the head is gated by valid.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= z_c;
  end

  // Head read and status outputs.
  always_comb begin
    m_data_out_z = m_valid_z ? mem_q[rd_ptr_q] : '0;
    fill         = fill_q;
    sat_count    = sat_count_q;
  end

endmodule

// File: tb/tb_y_requant_fifo.sv
// Randomized + directed bench for y_requant_fifo against a queue-based model.
module tb_y_requant_fifo;

  localparam int SHIFT = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] s_data_in_y;
  logic        s_valid_y;
  logic        s_ready_y;
  logic [7:0]  m_data_out_z;
  logic        m_valid_z;
  logic        m_ready_z;
  logic [3:0]  fill;
  logic [7:0]  sat_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq[$];
  int         msat = 0;

  y_requant_fifo dut (
    .clk(clk), .reset(reset),
    .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y),
    .m_data_out_z(m_data_out_z), .m_valid_z(m_valid_z), .m_ready_z(m_ready_z),
    .fill(fill), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  // Count one comparison and report a mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference transform from the arithmetic definition (floor division).
  function automatic void ref_tx(input int y, output logic [7:0] z, output bit sat);
    int v, r, q, d;
    v = y;
`ifdef Y_REQUANT_RELU_EN
    if (v < 0) v = 0;
`endif
    d = 1 << SHIFT;
    r = v + ((SHIFT > 0) ? d / 2 : 0);
    q = r / d;
    if ((r % d != 0) && (r < 0)) q = q - 1;
    sat = 1'b0;
    if (q > 127) begin q = 127; sat = 1'b1; end
    else if (q < -128) begin q = -128; sat = 1'b1; end
    z = 8'(q);
  endfunction

  // One clock: drive inputs, check outputs against model, advance model.
  task automatic cycle(input logic v, input logic [17:0] d, input logic rdy,
                       input logic rst, output bit pushed);
    bit push, pop, sat;
    logic [7:0] z;
    s_valid_y   = v;
    s_data_in_y = v ? d : 18'bx;
    m_ready_z   = rdy;
    reset       = rst;
    #1;
    check("s_ready_y", 32'(s_ready_y), 32'((!rst) && (mq.size() < DEPTH)));
    check("m_valid_z", 32'(m_valid_z), 32'(mq.size() != 0));
    check("fill", 32'(fill), 32'(mq.size()));
    check("sat_count", 32'(sat_count), 32'(msat));
    if (mq.size() != 0) check("head_data", 32'(m_data_out_z), 32'(mq[0]));
    push = v && !rst && (mq.size() < DEPTH);
    pop  = rdy && (mq.size() != 0);
    ref_tx(int'($signed(d)), z, sat);
    pushed = push;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      msat = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(z);
        if (sat && msat < 255) msat++;
      end
    end
  endtask

  int  dir_a[7] = '{400, 1600, 10, 22, 26, -20, -8};
  int  dir_b[3] = '{2800, -2800, 3600};
  int  dir_c[3] = '{-2800, -20, 2800};
  bit  pk;
  int  npush, budget;
  int  y;

  initial begin
    reset = 1'b1; s_valid_y = 1'b0; s_data_in_y = '0; m_ready_z = 1'b0;
    @(posedge clk); #1;
    cycle(1'b0, 18'd0, 1'b1, 1'b1, pk);
    check("reset_data", 32'(m_data_out_z), 32'd0);

    // Signed path vectors with consumer always ready.
    foreach (dir_a[i]) cycle(1'b1, 18'(dir_a[i]), 1'b1, 1'b0, pk);
    repeat (3) cycle(1'b0, 18'd0, 1'b1, 1'b0, pk);
    // Saturation and relu vectors.
    foreach (dir_b[i]) cycle(1'b1, 18'(dir_b[i]), 1'b1, 1'b0, pk);
    foreach (dir_c[i]) cycle(1'b1, 18'(dir_c[i]), 1'b1, 1'b0, pk);
    repeat (3) cycle(1'b0, 18'd0, 1'b1, 1'b0, pk);

    // Fill to full with consumer stalled; 9th sample is held.
    for (int i = 0; i < 9; i++) cycle(1'b1, 18'(100 * i - 300), 1'b0, 1'b0, pk);
    check("full_fill", 32'(fill), 32'd8);
    check("full_ready", 32'(s_ready_y), 32'd0);
    // One pop while full: push is not bypassed in that cycle.
    cycle(1'b1, 18'(500), 1'b1, 1'b0, pk);
    check("pop_full_nopush", 32'(pk), 32'd0);
    check("after_pop_fill", 32'(fill), 32'd7);
    cycle(1'b1, 18'(500), 1'b0, 1'b0, pk);
    check("ninth_accepted", 32'(pk), 32'd1);
    repeat (10) cycle(1'b0, 18'd0, 1'b1, 1'b0, pk);

    // Random traffic: 20 accepted pushes, X on idle data.
    npush = 0; budget = 0;
    while (npush < 20 && budget < 500) begin
      y = int'($urandom_range(0, 8191)) - 4096;
      cycle(1'($urandom_range(0, 1)), 18'(y), 1'($urandom_range(0, 1)), 1'b0, pk);
      if (pk) npush++;
      budget++;
      checks++;
      if (fill > 4'd8) begin
        failures++;
        $display("FAIL fill_bound: got %0d expected <= 8", fill);
      end
    end
    check("random_pushes", 32'(npush), 32'd20);
    budget = 0;
    while (mq.size() != 0 && budget < 100) begin
      cycle(1'b0, 18'd0, 1'($urandom_range(0, 1)), 1'b0, pk);
      budget++;
    end
    check("random_drained", 32'(mq.size()), 32'd0);

    // Reset mid-stream after 5 entries (one saturating to make sat nonzero).
    cycle(1'b1, 18'(3600), 1'b0, 1'b0, pk);
    for (int i = 0; i < 4; i++) cycle(1'b1, 18'(16 * i), 1'b0, 1'b0, pk);
    check("pre_reset_fill", 32'(fill), 32'd5);
    cycle(1'b0, 18'd0, 1'b0, 1'b1, pk);
    check("post_reset_fill", 32'(fill), 32'd0);
    check("post_reset_valid", 32'(m_valid_z), 32'd0);
    check("post_reset_sat", 32'(sat_count), 32'd0);
    check("post_reset_data", 32'(m_data_out_z), 32'd0);
    cycle(1'b1, 18'(400), 1'b0, 1'b0, pk);
    check("push400", 32'(m_data_out_z), 32'd25);
    check("push400_valid", 32'(m_valid_z), 32'd1);
    repeat (2) cycle(1'b0, 18'd0, 1'b1, 1'b0, pk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
